// File: rtl/mac_8bit_tap_seq.sv
// Tap sequencer and result collector for one MAC_8BIT unit: pairs streamed samples with local coefficients.
// Optional FRAME_CNT output is enabled by defining MAC_TAP_SEQ_FRAME_CNT_EN.
module mac_8bit_tap_seq #(
  parameter int NUM_TAPS = 16
) (
  input  logic       MAC_ACC_CLK,
  input  logic       MAC_ACC_RST,
  input  logic       CFG_COEF_WE,
  input  logic [3:0] CFG_COEF_ADDR,
  input  logic [7:0] CFG_COEF_WDATA,
  input  logic [3:0] CFG_TAPS,
  input  logic [5:0] CFG_OUT_SEL,
  input  logic       CFG_RND,
  input  logic       CFG_SAT,
  input  logic       CFG_TC,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  output logic       S_READY,
  output logic [7:0] M_DATA,
  output logic       M_VALID,
  input  logic       M_READY,
  output logic [7:0] MAC_OPER_DATA,
  output logic [7:0] MAC_COEF_DATA,
  output logic       EFPGA_MATHB_CLK_EN,
  output logic       MAC_ACC_CLEAR,
  output logic       MAC_ACC_RND,
  output logic       MAC_ACC_SAT,
  output logic       MAC_TC,
  output logic [5:0] MAC_OUT_SEL,
  input  logic [7:0] MAC_OUT,
  output logic       BUSY
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0] FRAME_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, ISSUE, CAPTURE} state_t;

  localparam logic [3:0] MAX_TAP = 4'(NUM_TAPS - 1);
  localparam logic [4:0] NT      = 5'(NUM_TAPS);

  state_t     state, state_nxt;
  logic [3:0] tap;
  logic [3:0] f_taps;
  logic [3:0] taps_clamp;
  logic [3:0] cur_taps;
  logic       first;
  logic       last;
  logic       hs;
  logic [7:0] coef [16];

  assign taps_clamp = (CFG_TAPS > MAX_TAP) ? MAX_TAP : CFG_TAPS;
  assign first      = (state == IDLE);
  // In IDLE the frame length is not latched yet, so look at the live config.
  assign cur_taps   = first ? taps_clamp : f_taps;
  assign last       = (tap == cur_taps);
  assign S_READY    = ~MAC_ACC_RST & (state == IDLE || state == RUN)
                      & ~(last & M_VALID & ~M_READY);
  assign hs         = S_VALID & S_READY;
  assign BUSY       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = last ? ISSUE : RUN;
      RUN:     if (hs && last) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge MAC_ACC_CLK or posedge MAC_ACC_RST) begin
    if (MAC_ACC_RST) begin
      state <= IDLE;
      tap   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) tap <= last ? 4'd0 : tap + 4'd1;
    end
  end

  // Coefficients are deliberately not reset; a same-edge read sees the old value.
  always_ff @(posedge MAC_ACC_CLK) begin
    if (CFG_COEF_WE && ({1'b0, CFG_COEF_ADDR} < NT))
      coef[CFG_COEF_ADDR] <= CFG_COEF_WDATA;
  end

  always_ff @(posedge MAC_ACC_CLK or posedge MAC_ACC_RST) begin
    if (MAC_ACC_RST) begin
      f_taps      <= '0;
      MAC_OUT_SEL <= '0;
      MAC_ACC_SAT <= 1'b0;
      MAC_TC      <= 1'b0;
    end else if (hs && first) begin
      f_taps      <= taps_clamp;
      MAC_OUT_SEL <= CFG_OUT_SEL;
      MAC_ACC_SAT <= CFG_SAT;
      MAC_TC      <= CFG_TC;
    end
  end

  // Exactly one of CLEAR/RND on tap 0 restarts the accumulator.
  always_ff @(posedge MAC_ACC_CLK or posedge MAC_ACC_RST) begin
    if (MAC_ACC_RST) begin
      MAC_OPER_DATA      <= '0;
      MAC_COEF_DATA      <= '0;
      EFPGA_MATHB_CLK_EN <= 1'b0;
      MAC_ACC_CLEAR      <= 1'b0;
      MAC_ACC_RND        <= 1'b0;
    end else begin
      EFPGA_MATHB_CLK_EN <= hs;
      MAC_ACC_RND        <= hs & first & CFG_RND;
      MAC_ACC_CLEAR      <= hs & first & ~CFG_RND;
      if (hs) begin
        MAC_OPER_DATA <= S_DATA;
        MAC_COEF_DATA <= coef[tap];
      end
    end
  end

  always_ff @(posedge MAC_ACC_CLK or posedge MAC_ACC_RST) begin
    if (MAC_ACC_RST) begin
      M_DATA  <= '0;
      M_VALID <= 1'b0;
    end else if (state == CAPTURE) begin
      M_DATA  <= MAC_OUT;
      M_VALID <= 1'b1;
    end else if (M_VALID && M_READY) begin
      M_VALID <= 1'b0;
    end
  end

`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
  always_ff @(posedge MAC_ACC_CLK or posedge MAC_ACC_RST) begin
    if (MAC_ACC_RST)             FRAME_CNT <= '0;
    else if (state == CAPTURE)   FRAME_CNT <= FRAME_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mac_8bit_tap_seq.sv
// Bench for mac_8bit_tap_seq: includes a MAC_8BIT stand-in and a frame-level reference model.
module tb_mac_8bit_tap_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [3:0] cfg_taps;
  logic [5:0] cfg_sel;
  logic       cfg_rnd, cfg_sat, cfg_tc;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_ready;
  logic [7:0] oper, coefd, mac_out;
  logic       en, clr, rnd_o, sat_o, tc_o, busy;
  logic [5:0] sel_o;
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  mac_8bit_tap_seq dut (
    .MAC_ACC_CLK(clk), .MAC_ACC_RST(rst),
    .CFG_COEF_WE(cfg_we), .CFG_COEF_ADDR(cfg_addr), .CFG_COEF_WDATA(cfg_wdata),
    .CFG_TAPS(cfg_taps), .CFG_OUT_SEL(cfg_sel), .CFG_RND(cfg_rnd),
    .CFG_SAT(cfg_sat), .CFG_TC(cfg_tc),
    .S_DATA(s_data), .S_VALID(s_valid), .S_READY(s_ready),
    .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready),
    .MAC_OPER_DATA(oper), .MAC_COEF_DATA(coefd),
    .EFPGA_MATHB_CLK_EN(en), .MAC_ACC_CLEAR(clr), .MAC_ACC_RND(rnd_o),
    .MAC_ACC_SAT(sat_o), .MAC_TC(tc_o), .MAC_OUT_SEL(sel_o),
    .MAC_OUT(mac_out), .BUSY(busy)
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
    , .FRAME_CNT(frame_cnt)
`endif
  );

  // Stand-in for the attached MAC: 24-bit accumulator, shift, optional saturation.
  logic [23:0] mac_acc, mac_prod, mac_half, mac_sh;
  always_comb begin
    mac_prod = tc_o ? ({{16{oper[7]}}, oper} * {{16{coefd[7]}}, coefd})
                    : ({16'b0, oper} * {16'b0, coefd});
    mac_half = (sel_o != 6'd0) ? (24'd1 << (sel_o - 6'd1)) : 24'd0;
    mac_sh   = tc_o ? 24'($signed(mac_acc) >>> sel_o) : (mac_acc >> sel_o);
    mac_out  = mac_sh[7:0];
    if (sat_o) begin
      if (!tc_o && (mac_sh[23:8] != 16'd0)) mac_out = 8'hFF;
      if (tc_o && (mac_sh[23:7] != {17{mac_sh[23]}})) mac_out = mac_sh[23] ? 8'h80 : 8'h7F;
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) mac_acc <= '0;
    else if (en) begin
      if (clr)        mac_acc <= mac_prod;
      else if (rnd_o) mac_acc <= mac_prod + mac_half;
      else            mac_acc <= mac_acc + mac_prod;
    end
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a frame is a dot product, then round/shift/saturate.
  function automatic longint tap_prod(input logic [7:0] d, input logic [7:0] c, input bit tc);
    if (tc) return longint'($signed(d)) * longint'($signed(c));
    return longint'(d) * longint'(c);
  endfunction

  function automatic int frame_result(input longint s, input logic [5:0] sel,
                                      input bit rnd, input bit sat, input bit tc);
    longint v;
    v = s;
    if (rnd && sel != 6'd0) v = v + (longint'(1) << (sel - 6'd1));
    v = v >>> sel;
    if (sat) begin
      if (tc) begin
        if (v > 127) v = 127;
        if (v < -128) v = -128;
      end else if (v > 255) v = 255;
    end
    return int'(v & 255);
  endfunction

  logic [7:0] tb_coef [16];
  int         m_tap, cd, pend, exp_md, exp_fc;
  bit         exp_mv, f_rnd, f_sat, f_tc;
  longint     sum;
  logic [5:0] f_sel;
  int         f_taps;

  always @(negedge clk) begin
    bit exp_rdy, last, hs;
    if (rst) begin
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data",  int'(m_data), 0);
      chk("rst_busy",    int'(busy), 0);
      chk("rst_oper",    int'(oper), 0);
      chk("rst_coef",    int'(coefd), 0);
      chk("rst_ctrl",    int'({en, clr, rnd_o, sat_o, tc_o}), 0);
      chk("rst_sel",     int'(sel_o), 0);
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
      chk("rst_frame_cnt", int'(frame_cnt), 0);
`endif
      m_tap = 0; cd = 0; exp_mv = 0; exp_md = 0; sum = 0; exp_fc = 0;
      f_sel = 0; f_rnd = 0; f_sat = 0; f_tc = 0; f_taps = 0;
    end else begin
      last    = (m_tap == ((m_tap == 0) ? int'(cfg_taps) : f_taps));
      exp_rdy = (cd == 0) && !(last && exp_mv && !m_ready);
      chk("s_ready", int'(s_ready), int'(exp_rdy));
      chk("busy",    int'(busy), int'((m_tap != 0) || (cd != 0)));
      chk("m_valid", int'(m_valid), int'(exp_mv));
      chk("m_data",  int'(m_data), exp_md);
      chk("out_sel", int'(sel_o), int'(f_sel));
      chk("sat_tc",  int'({sat_o, tc_o}), int'({f_sat, f_tc}));
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
      chk("frame_cnt", int'(frame_cnt), exp_fc);
`endif
      if (cd == 1) begin
        exp_mv = 1; exp_md = pend; exp_fc = (exp_fc + 1) & 16'hFFFF;
      end else if (m_ready) exp_mv = 0;
      if (cd > 0) cd--;
      hs = s_valid && exp_rdy;
      if (hs) begin
        if (m_tap == 0) begin
          f_sel = cfg_sel; f_rnd = cfg_rnd; f_sat = cfg_sat; f_tc = cfg_tc;
          f_taps = int'(cfg_taps); sum = 0;
        end
        sum = sum + tap_prod(s_data, tb_coef[m_tap], f_tc);
        if (m_tap == f_taps) begin
          pend = frame_result(sum, f_sel, f_rnd, f_sat, f_tc);
          cd = 2; m_tap = 0;
        end else m_tap++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = 4'(a); cfg_wdata = d; tb_coef[a] = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic set_cfg(input int taps, input int sel, input bit r, input bit s, input bit t);
    cfg_taps = 4'(taps); cfg_sel = 6'(sel); cfg_rnd = r; cfg_sat = s; cfg_tc = t;
  endtask

  task automatic send_taps(input logic [7:0] s [4], input int n);
    for (int i = 0; i < n; i++) begin
      int  g;
      bit  ok;
      g = 0;
      s_valid = 1; s_data = s[i];
      do begin
        @(negedge clk); ok = s_ready;
        tick(); g++;
      end while (!ok && g < 50);
      if (!ok) chk("handshake_timeout", 0, 1);
    end
    s_valid = 0;
  endtask

  task automatic wait_result(input string nm, input logic [7:0] exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 20);
    chk({nm, "_latency"}, n, 3);
    chk(nm, int'(m_data), int'(exp));
    tick();
  endtask

  initial begin
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; s_data = 0; s_valid = 0; m_ready = 1;
    set_cfg(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) tb_coef[i] = 8'h00;
    for (int i = 0; i < 16; i++) write_coef(i, 8'h00);
    repeat (2) tick();
    rst = 0;
    @(negedge clk);
    chk("rel_s_ready", int'(s_ready), 1);
    chk("rel_busy", int'(busy), 0);
    tick();

    for (int i = 0; i < 4; i++) write_coef(i, 8'(i + 1));
    set_cfg(3, 0, 0, 0, 0);
    send_taps('{8'd10, 8'd20, 8'd30, 8'd40}, 4);
    wait_result("unsigned", 8'h2C);

    set_cfg(3, 0, 0, 1, 0);
    send_taps('{8'd10, 8'd20, 8'd30, 8'd40}, 4);
    wait_result("saturate", 8'hFF);

    write_coef(0, 8'hFF); write_coef(1, 8'h02);
    set_cfg(1, 0, 0, 0, 1);
    send_taps('{8'h05, 8'hFD, 8'h00, 8'h00}, 2);
    wait_result("signed", 8'hF5);

    write_coef(0, 8'h01);
    set_cfg(0, 2, 1, 0, 0);
    send_taps('{8'd6, 8'd0, 8'd0, 8'd0}, 1);
    wait_result("round_on", 8'h02);
    set_cfg(0, 2, 0, 0, 0);
    send_taps('{8'd6, 8'd0, 8'd0, 8'd0}, 1);
    wait_result("round_off", 8'h01);

    // Backpressure: hold 0x2C, next frame must stall on its last tap.
    for (int i = 0; i < 4; i++) write_coef(i, 8'(i + 1));
    set_cfg(3, 0, 0, 0, 0);
    m_ready = 0;
    send_taps('{8'd10, 8'd20, 8'd30, 8'd40}, 4);
    wait_result("bp_frame1", 8'h2C);
    send_taps('{8'd40, 8'd30, 8'd20, 8'd0}, 3);
    s_valid = 1; s_data = 8'd10;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", int'(s_ready), 0);
      chk("bp_hold", int'(m_data), 8'h2C);
      tick();
    end
    m_ready = 1;
    @(negedge clk);
    chk("bp_release", int'(s_ready), 1);
    tick();
    m_ready = 0; s_valid = 0;
    wait_result("bp_frame2", 8'hC8);
    m_ready = 1;
    tick();

    // Reset mid-frame, then a clean rerun.
    send_taps('{8'd10, 8'd20, 8'd30, 8'd40}, 2);
    rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    send_taps('{8'd10, 8'd20, 8'd30, 8'd40}, 4);
    wait_result("after_reset", 8'h2C);
`ifdef MAC_TAP_SEQ_FRAME_CNT_EN
    chk("frame_cnt_after_reset", int'(frame_cnt), 1);
`endif
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
